bridge_rx_fc: RTL and testbench

Receive-side flow-control manager for the PCIe bridge. It owns the core's flow-control select port and periodically steps it to the receive-credits-available view. It latches the receive header and data credit counts and drives the core's non-posted-OK input with hysteresis. It also raises a posted-hold flag for the Rx bridge and, optionally, time-shares the same port to refresh the transmit credit flags.

---
 rtl/bridge_rx_fc.sv | 165 ++++++++++++++++
 tb/tb_bridge_rx_fc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bridge_rx_fc.sv
// Receive-side flow-control manager: sweeps the core's fc_sel port, latches Rx credits,
// drives np_ok with hysteresis and Posted_Hold. Optional Tx sampling: BRIDGE_RXFC_TXSAMPLE_EN.
module bridge_rx_fc #(
  parameter int FC_LATENCY = 2,
  parameter int REFRESH    = 16,
  parameter int NPH_LOW    = 2,
  parameter int NPH_HIGH   = 4,
  parameter int NPD_LOW    = 8,
  parameter int NPD_HIGH   = 16
) (
  input  logic        Rxfc_CLK,
  input  logic        Rxfc_RST,
  input  logic        Rxfc_Link_Up,
  input  logic [7:0]  Rxfc_fc_ph,
  input  logic [7:0]  Rxfc_fc_nph,
  input  logic [7:0]  Rxfc_fc_cplh,
  input  logic [11:0] Rxfc_fc_pd,
  input  logic [11:0] Rxfc_fc_npd,
  input  logic [11:0] Rxfc_fc_cpld,
  output logic [2:0]  Rxfc_fc_sel,
  output logic        Rxfc_np_ok,
  output logic        Rxfc_Posted_Hold,
  output logic        Rxfc_Snap_Valid,
  output logic [5:0]  Rxfc_Tx_FC
);

  localparam int CNT_MAX = (FC_LATENCY > REFRESH) ? FC_LATENCY : REFRESH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LAT_LOAD = CW'(FC_LATENCY - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(REFRESH - 1);

  localparam logic [7:0]  NPH_LO = 8'(NPH_LOW);
  localparam logic [7:0]  NPH_HI = 8'(NPH_HIGH);
  localparam logic [11:0] NPD_LO = 12'(NPD_LOW);
  localparam logic [11:0] NPD_HI = 12'(NPD_HIGH);

  localparam logic [2:0] SEL_RX_VIEW = 3'b000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL_RX = 3'd1,
    CAP_RX = 3'd2,
`ifdef BRIDGE_RXFC_TXSAMPLE_EN
    SEL_TX = 3'd3,
    CAP_TX = 3'd4,
`endif
    GAP    = 3'd5
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           np_ok_q;
  logic           posted_hold_q;
  logic           snap_q;

  // Completion credits only feed the Tx flags; their low bits are never looked at.
  logic unused_counts;
  assign unused_counts = ^{Rxfc_fc_cplh, Rxfc_fc_cpld};

`ifdef BRIDGE_RXFC_TXSAMPLE_EN
  localparam logic [2:0] SEL_TX_VIEW = 3'b100;
  logic [2:0] sel_q;
  logic [5:0] tx_fc_q;

  always_ff @(posedge Rxfc_CLK or negedge Rxfc_RST) begin
    if (!Rxfc_RST) begin
      sel_q   <= SEL_RX_VIEW;
      tx_fc_q <= 6'b000000;
    end else if (!Rxfc_Link_Up) begin
      sel_q   <= SEL_RX_VIEW;
      tx_fc_q <= 6'b000000;
    end else begin
      case (state)
        CAP_RX: sel_q <= SEL_TX_VIEW;
        CAP_TX: begin
          sel_q   <= SEL_RX_VIEW;
          tx_fc_q <= {|Rxfc_fc_cpld[11:10], |Rxfc_fc_cplh[7:5],
                      |Rxfc_fc_npd[11:10],  |Rxfc_fc_nph[7:5],
                      |Rxfc_fc_pd[11:10],   |Rxfc_fc_ph[7:5]};
        end
        default: sel_q <= sel_q;
      endcase
    end
  end

  assign Rxfc_fc_sel = sel_q;
  assign Rxfc_Tx_FC  = tx_fc_q;
`else
  // Without Tx sampling the port never leaves the Rx view and Tx throttling is the core's job.
  assign Rxfc_fc_sel = SEL_RX_VIEW;
  assign Rxfc_Tx_FC  = 6'b111111;
`endif

  always_ff @(posedge Rxfc_CLK or negedge Rxfc_RST) begin
    if (!Rxfc_RST) begin
      state         <= IDLE;
      cnt           <= '0;
      np_ok_q       <= 1'b0;
      posted_hold_q <= 1'b1;
      snap_q        <= 1'b0;
    end else if (!Rxfc_Link_Up) begin
      state         <= IDLE;
      cnt           <= '0;
      np_ok_q       <= 1'b0;
      posted_hold_q <= 1'b1;
      snap_q        <= 1'b0;
    end else begin
      snap_q <= 1'b0;
      case (state)
        IDLE: begin
          state <= SEL_RX;
          cnt   <= LAT_LOAD;
        end
        SEL_RX: begin
          if (cnt == '0) state <= CAP_RX;
          else           cnt   <= cnt - 1'b1;
        end
        CAP_RX: begin
          snap_q        <= 1'b1;
          posted_hold_q <= (Rxfc_fc_ph == 8'd0) || (Rxfc_fc_pd == 12'd0);
          // Drop wins over restore; between the thresholds np_ok keeps its last value.
          if ((Rxfc_fc_nph < NPH_LO) || (Rxfc_fc_npd < NPD_LO))
            np_ok_q <= 1'b0;
          else if ((Rxfc_fc_nph >= NPH_HI) && (Rxfc_fc_npd >= NPD_HI))
            np_ok_q <= 1'b1;
`ifdef BRIDGE_RXFC_TXSAMPLE_EN
          state <= SEL_TX;
          cnt   <= LAT_LOAD;
`else
          state <= GAP;
          cnt   <= GAP_LOAD;
`endif
        end
`ifdef BRIDGE_RXFC_TXSAMPLE_EN
        SEL_TX: begin
          if (cnt == '0) state <= CAP_TX;
          else           cnt   <= cnt - 1'b1;
        end
        CAP_TX: begin
          state <= GAP;
          cnt   <= GAP_LOAD;
        end
`endif
        GAP: begin
          if (cnt == '0) begin
            state <= SEL_RX;
            cnt   <= LAT_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign Rxfc_np_ok       = np_ok_q;
  assign Rxfc_Posted_Hold = posted_hold_q;
  assign Rxfc_Snap_Valid  = snap_q;

endmodule

// File: tb/tb_bridge_rx_fc.sv
// Directed bench for bridge_rx_fc: core credit model with fc_sel latency, scoreboard of
// expected Rx/Tx flags compared at each Snap_Valid.
module tb_bridge_rx_fc;
  localparam int FCL = 2;
`ifdef BRIDGE_RXFC_TXSAMPLE_EN
  localparam int         PERIOD = 2 * (FCL + 1) + 16;
  localparam logic [5:0] TX_RST = 6'b000000;
  localparam bit         TXEN   = 1'b1;
`else
  localparam int         PERIOD = FCL + 1 + 16;
  localparam logic [5:0] TX_RST = 6'b111111;
  localparam bit         TXEN   = 1'b0;
`endif

  typedef struct {
    logic       np_ok;
    logic       hold;
    logic [5:0] tx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_up = 1'b0;
  logic [7:0]  ph, nph, cplh;
  logic [11:0] pd, npd, cpld;
  logic [2:0]  fc_sel;
  logic        np_ok, posted_hold, snap;
  logic [5:0]  tx_fc;

  logic [7:0]  rx_ph, rx_nph, rx_cplh, tx_ph, tx_nph, tx_cplh;
  logic [11:0] rx_pd, rx_npd, rx_cpld, tx_pd, tx_npd, tx_cpld;
  logic [2:0]  sel_pipe [FCL];
  bit          sel_left_rx = 1'b0;
  logic        model_np = 1'b0;
  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail = 0;

  bridge_rx_fc dut (
    .Rxfc_CLK(clk), .Rxfc_RST(rst_n), .Rxfc_Link_Up(link_up),
    .Rxfc_fc_ph(ph), .Rxfc_fc_nph(nph), .Rxfc_fc_cplh(cplh),
    .Rxfc_fc_pd(pd), .Rxfc_fc_npd(npd), .Rxfc_fc_cpld(cpld),
    .Rxfc_fc_sel(fc_sel), .Rxfc_np_ok(np_ok), .Rxfc_Posted_Hold(posted_hold),
    .Rxfc_Snap_Valid(snap), .Rxfc_Tx_FC(tx_fc)
  );

  always #5 clk = ~clk;

  // Core model: counts follow fc_sel FCL cycles late.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FCL; i++) sel_pipe[i] <= 3'b000;
    end else begin
      sel_pipe[0] <= fc_sel;
      for (int i = 1; i < FCL; i++) sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  always_comb begin
    ph = rx_ph; nph = rx_nph; cplh = rx_cplh;
    pd = rx_pd; npd = rx_npd; cpld = rx_cpld;
    if (sel_pipe[FCL-1] == 3'b100) begin
      ph = tx_ph; nph = tx_nph; cplh = tx_cplh;
      pd = tx_pd; npd = tx_npd; cpld = tx_cpld;
    end
  end

  always @(negedge clk) if (fc_sel != 3'b000) sel_left_rx <= 1'b1;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_np(input logic cur, input logic [7:0] h, input logic [11:0] d);
    if (h < 8'd2 || d < 12'd8) return 1'b0;
    if (h >= 8'd4 && d >= 12'd16) return 1'b1;
    return cur;
  endfunction

  function automatic logic [5:0] tx_expect();
    if (!TXEN) return 6'b111111;
    return {tx_cpld[11:10] != 2'b00, tx_cplh[7:5] != 3'b000,
            tx_npd[11:10] != 2'b00,  tx_nph[7:5] != 3'b000,
            tx_pd[11:10] != 2'b00,   tx_ph[7:5] != 3'b000};
  endfunction

  task automatic wait_snap(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!snap && cyc < 200);
    check({tag, "_snap_seen"}, int'(snap), 1);
  endtask

  // New values take effect at the next Rx capture and the Tx capture that follows it.
  task automatic sweep(input string tag);
    exp_t e;
    int c;
    model_np = next_np(model_np, rx_nph, rx_npd);
    e.np_ok = model_np;
    e.hold  = (rx_ph == 8'd0) || (rx_pd == 12'd0);
    e.tx    = tx_expect();
    sb.push_back(e);
    wait_snap(tag, c);
    e = sb.pop_front();
    check({tag, "_np_ok"}, int'(np_ok), int'(e.np_ok));
    check({tag, "_hold"}, int'(posted_hold), int'(e.hold));
    wait_snap(tag, c);
    check({tag, "_period"}, c, PERIOD);
    check({tag, "_tx_fc"}, int'(tx_fc), int'(e.tx));
  endtask

  initial begin
    int c;
    rx_ph = 8'd8;  rx_nph = 8'd8;  rx_cplh = 8'd0;
    rx_pd = 12'd64; rx_npd = 12'd64; rx_cpld = 12'd0;
    tx_ph = 8'h20; tx_nph = 8'h00; tx_cplh = 8'h00;
    tx_pd = 12'h400; tx_npd = 12'h000; tx_cpld = 12'h000;

    repeat (3) @(negedge clk);
    check("rst_fc_sel", int'(fc_sel), 0);
    check("rst_np_ok", int'(np_ok), 0);
    check("rst_hold", int'(posted_hold), 1);
    check("rst_snap", int'(snap), 0);
    check("rst_tx_fc", int'(tx_fc), int'(TX_RST));

    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_snap", int'(snap), 0);

    // First capture lands FCL+1 edges after the edge that leaves IDLE.
    link_up = 1'b1;
    wait_snap("first", c);
    check("first_latency", c, FCL + 2);
    model_np = next_np(model_np, rx_nph, rx_npd);
    check("first_np_ok", int'(np_ok), int'(model_np));
    check("first_hold", int'(posted_hold), 0);
    check("first_sel_after_cap", int'(fc_sel), TXEN ? 4 : 0);
    @(negedge clk);
    check("snap_one_cycle", int'(snap), 0);
    wait_snap("second", c);
    check("period", c + 1, PERIOD);
    check("first_tx_fc", int'(tx_fc), int'(tx_expect()));

    rx_nph = 8'd1;    sweep("nph1");
    rx_nph = 8'd3;    sweep("nph3");
    rx_nph = 8'd4;    sweep("nph4");
    rx_npd = 12'd15;  sweep("npd15");
    rx_npd = 12'd7;   sweep("npd7");
    rx_npd = 12'd16;  sweep("npd16");
    rx_npd = 12'd64;
    rx_pd = 12'd0;    sweep("pd0");
    rx_pd = 12'd1;    sweep("pd1");
    rx_ph = 8'd0;     sweep("ph0");
    rx_ph = 8'd8;     sweep("ph8");

    tx_ph = 8'h1f; tx_pd = 12'h3ff; tx_nph = 8'h80;
    tx_npd = 12'h800; tx_cplh = 8'he0; tx_cpld = 12'hc00;
    sweep("txpat2");
    rx_nph = 8'd0;    sweep("rxnph0_txhigh");
    tx_ph = 8'h20; tx_pd = 12'h400; tx_nph = 8'h00;
    tx_npd = 12'h000; tx_cplh = 8'h00; tx_cpld = 12'h000;
    sweep("txpat1");
    rx_nph = 8'd8;    sweep("rxnph8_txzero");

    // Link drop right after a capture (inside SEL_TX when Tx sampling is built).
    check("pre_drop_sel", int'(fc_sel), TXEN ? 4 : 0);
    link_up = 1'b0;
    @(negedge clk);
    check("drop_np_ok", int'(np_ok), 0);
    check("drop_hold", int'(posted_hold), 1);
    check("drop_tx_fc", int'(tx_fc), int'(TX_RST));
    check("drop_fc_sel", int'(fc_sel), 0);
    model_np = 1'b0;

    // Link falls on what would be the capture edge: nothing is captured.
    link_up = 1'b1;
    repeat (FCL + 1) @(negedge clk);
    link_up = 1'b0;
    @(negedge clk);
    check("capedge_snap", int'(snap), 0);
    check("capedge_np_ok", int'(np_ok), 0);
    check("capedge_hold", int'(posted_hold), 1);

    // Asynchronous reset between edges, mid-SEL_TX.
    link_up = 1'b1;
    wait_snap("pre_rst", c);
    check("relink_latency", c, FCL + 2);
    model_np = next_np(model_np, rx_nph, rx_npd);
    check("pre_rst_np_ok", int'(np_ok), int'(model_np));
    #2 rst_n = 1'b0;
    #1;
    check("arst_np_ok", int'(np_ok), 0);
    check("arst_hold", int'(posted_hold), 1);
    check("arst_fc_sel", int'(fc_sel), 0);
    check("arst_tx_fc", int'(tx_fc), int'(TX_RST));
    @(negedge clk);
    rst_n = 1'b1;
    wait_snap("post_rst", c);
    check("post_rst_latency", c, FCL + 2);
    check("post_rst_np_ok", int'(np_ok), 1);
    check("post_rst_hold", int'(posted_hold), 0);

    check("sel_left_rx_view", int'(sel_left_rx), int'(TXEN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
